// File: rtl/seq_div_recon.sv
// seq_div_recon: rebuilds an 8-bit dividend as q*d + r by shift-and-add over the quotient bits.
// Latency: start sampled at edge N -> done high (and dvd valid) in the cycle after edge N+5.
// Backpressure: none; start is accepted only in IDLE and ignored while busy or in DONE.
// Optional macro RECON_ERR_CHECK_EN: builds the remainder-range check driving err (tied low otherwise).

module seq_div_recon (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] q,
    input  logic [3:0] d,
    input  logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic [7:0] dvd,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] q_q, q_d;
    logic [3:0] d_q, d_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [7:0] dvd_q, dvd_d;
    logic [7:0] addend;

`ifdef RECON_ERR_CHECK_EN
    logic [3:0] r_q, r_d;
    logic       err_q, err_d;
`endif

    // Partial product for the current quotient bit: divisor weighted by 2^idx.
    always_comb begin
        addend = {4'b0000, d_q} << idx_q;
    end

    // Next-state and datapath update; outputs other than busy are registered.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        dvd_d   = dvd_q;
`ifdef RECON_ERR_CHECK_EN
        r_d     = r_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Operands are frozen here so later input changes cannot leak in.
                    q_d     = q;
                    d_d     = d;
                    acc_d   = {4'b0000, r};
                    idx_d   = 2'd0;
                    state_d = RUN;
`ifdef RECON_ERR_CHECK_EN
                    r_d     = r;
`endif
                end
            end
            RUN: begin
                // One quotient bit per cycle, LSB first; zero bits still cost a cycle.
                if (q_q[idx_q]) begin
                    acc_d = acc_q + addend;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dvd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef RECON_ERR_CHECK_EN
                // A zero divisor or a remainder not below the divisor is not a legal division.
                err_d   = (d_q == 4'd0) | (r_q >= d_q);
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any start or in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= 4'd0;
            d_q     <= 4'd0;
            acc_q   <= 8'd0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            dvd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            dvd_q   <= dvd_d;
        end
    end

`ifdef RECON_ERR_CHECK_EN
    // Captured remainder and error flag; err holds until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // busy covers the RUN cycles and the DONE cycle, dropping as done pulses.
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dvd  = dvd_q;

endmodule

// File: doc/seq_div_recon.md
SEQ_DIV_RECON -- requirements
Module: seq_div_recon

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to reconstruct a dividend from the presented operands.
REQ-005 q  input  4  quotient from the 4-bit parallel divider.
REQ-006 d  input  4  divisor.
REQ-007 r  input  4  remainder.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse when dvd is updated.
REQ-010 dvd  output  8  reconstructed dividend, dvd = q*d + r.
REQ-011 err  output  1  remainder-range violation flag (see Configuration).

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture q, d and r, load the internal 8-bit accumulator with zero-extended r, clear the bit index, assert busy on the next cycle and enter RUN.
REQ-014 In RUN, the block SHALL process one quotient bit per cycle, LSB first: if q[i]=1 then acc += d << i; otherwise acc is unchanged.
REQ-015 After bit 3, the block SHALL enter DONE, copy acc to dvd, pulse done for exactly one cycle, deassert busy and return to IDLE.
REQ-016 Latency: for start sampled at edge N, done SHALL be high during the cycle following edge N+5, and dvd SHALL be valid from that cycle.
REQ-017 Arithmetic SHALL be unsigned 8-bit; the maximum result 15*15+15 = 240 fits, so no overflow is possible.
REQ-018 dvd and err SHALL hold their last values until the next done pulse.
REQ-019 start asserted while busy=1 or in DONE SHALL be ignored and SHALL NOT alter captured operands.
REQ-020 Input changes after capture SHALL NOT affect the result.
REQ-021 d=0 SHALL yield dvd = r with normal latency.
REQ-022 q=0 SHALL still take the full 4 RUN cycles.
REQ-023 start held high continuously SHALL launch a new operation on the first IDLE cycle after each DONE.

Reset
REQ-024 When rst=1, the block SHALL force state=IDLE, busy=0, done=0, dvd=8'h00, err=0, and clear acc and the bit index.
REQ-025 rst SHALL take priority over start and over any in-flight operation.
REQ-026 A reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-027 While rst=1, start SHALL be ignored.

Configuration
REQ-028 Macro RECON_ERR_CHECK_EN SHALL control the remainder-range check.
REQ-029 With RECON_ERR_CHECK_EN defined, err SHALL be updated together with done to (d == 0) | (r >= d), using the captured operands.
REQ-030 With RECON_ERR_CHECK_EN undefined, err SHALL be tied to 0 and no comparison logic SHALL be built; all other behaviour is identical.

Verification
REQ-031 q=5, d=3, r=2, start pulse -> busy for 5 cycles, done pulse 5 edges later, dvd=8'd17, err=0.
REQ-032 q=15, d=15, r=14 -> dvd=8'd239, err=0; then q=0, d=9, r=4 -> dvd=8'd4 after full latency.
REQ-033 With macro defined: q=9, d=0, r=7 -> dvd=8'd7, err=1; q=2, d=3, r=3 -> dvd=8'd9, err=1. With macro undefined, the same stimulus gives err=0.
REQ-034 Start q=6, d=5, r=1, then during RUN pulse start with q=1, d=1, r=0 and change inputs -> single done, dvd=8'd31, second start ignored.
REQ-035 Start an operation, assert rst in the 3rd RUN cycle -> no done, busy=0, dvd=0 next cycle; a subsequent start with q=3, d=4, r=2 -> dvd=8'd14.
REQ-036 start held high for 20 cycles with q=2, d=7, r=1 -> back-to-back operations, done every 6 cycles, dvd=8'd15 each time.
